// File: rtl/bats_renderer.sv
// Left/right bat renderer: per-bat vertical sequencer (IDLE/ARMED/ACTIVE),
// horizontal window compare, registered pixel/segment outputs, and
// sticky ball/bat collision flags.
// Optional feature macro: BATS_COLLISION_EN (collision detection compiled in).
module bats_renderer #(
    parameter int unsigned HBITS      = 4,
    parameter int unsigned BAT_WIDTH  = 4,
    parameter logic [8:0]  LEFT_HPOS  = 9'd16,
    parameter logic [8:0]  RIGHT_HPOS = 9'd236
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] hpos,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       left_start,
    input  logic       right_start,
    input  logic       ball_gfx,
    output logic       left_on,
    output logic       right_on,
    output logic       display_on,
    output logic [2:0] left_seg,
    output logic [2:0] right_seg,
    output logic       left_hit,
    output logic       right_hit
);

    localparam int unsigned NBATS = 2;
    localparam logic [HBITS-1:0] CNT_MAX = '1;
    localparam logic [9:0] L_LO = {1'b0, LEFT_HPOS};
    localparam logic [9:0] L_HI = L_LO + 10'(BAT_WIDTH) - 10'd1;
    localparam logic [9:0] R_LO = {1'b0, RIGHT_HPOS};
    localparam logic [9:0] R_HI = R_LO + 10'(BAT_WIDTH) - 10'd1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

    state_e           state_q [NBATS];
    state_e           state_d [NBATS];
    logic [HBITS-1:0] cnt_q   [NBATS];
    logic [HBITS-1:0] cnt_d   [NBATS];

    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             line_edge_c;
    logic             vsync_edge_c;
    logic [NBATS-1:0] start_c;
    logic [NBATS-1:0] hwin_c;
    logic [9:0]       hpos_ext_c;

    logic [NBATS-1:0] on_q, on_d;
    logic [NBATS-1:0] hit_q, hit_d;
    logic [2:0]       seg_q [NBATS];
    logic [2:0]       seg_d [NBATS];
    logic             disp_q, disp_d;

    assign hsync_d      = hsync;
    assign vsync_d      = vsync;
    assign line_edge_c  = hsync & ~hsync_q;
    assign vsync_edge_c = vsync & ~vsync_q;
    assign start_c      = {right_start, left_start};
    assign hpos_ext_c   = {1'b0, hpos};

    // Sequencer state, line counters and sync edge-detect registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            for (int i = 0; i < NBATS; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            for (int i = 0; i < NBATS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Next-state logic; a start pulse always wins over a coincident line edge.
    always_comb begin
        for (int i = 0; i < NBATS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (start_c[i]) begin
                        state_d[i] = ST_ARMED;
                        cnt_d[i]   = '0;
                    end
                end
                ST_ARMED: begin
                    if (start_c[i]) begin
                        state_d[i] = ST_ARMED;
                        cnt_d[i]   = '0;
                    end else if (line_edge_c) begin
                        state_d[i] = ST_ACTIVE;
                        cnt_d[i]   = '0;
                    end
                end
                ST_ACTIVE: begin
                    if (start_c[i]) begin
                        state_d[i] = ST_ARMED;
                        cnt_d[i]   = '0;
                    end else if (line_edge_c) begin
                        if (cnt_q[i] == CNT_MAX) begin
                            state_d[i] = ST_IDLE;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + HBITS'(1);
                        end
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Pixel, segment and collision values to be registered this cycle.
    always_comb begin
        hwin_c[0] = (hpos_ext_c >= L_LO) && (hpos_ext_c <= L_HI);
        hwin_c[1] = (hpos_ext_c >= R_LO) && (hpos_ext_c <= R_HI);
        for (int i = 0; i < NBATS; i++) begin
            on_d[i]  = (state_q[i] == ST_ACTIVE) && hwin_c[i];
            seg_d[i] = (state_q[i] == ST_ACTIVE) ? cnt_q[i][HBITS-1 -: 3] : 3'd0;
        end
        disp_d = |on_d;
`ifdef BATS_COLLISION_EN
        for (int i = 0; i < NBATS; i++) begin
            hit_d[i] = hit_q[i];
            if (vsync_edge_c) begin
                hit_d[i] = 1'b0;
            end
            if (ball_gfx && on_q[i]) begin
                hit_d[i] = 1'b1;
            end
        end
`else
        hit_d = '0;
`endif
    end

`ifndef BATS_COLLISION_EN
    // Collision inputs have no consumer in this build.
    logic unused_collision;
    assign unused_collision = ball_gfx ^ vsync_edge_c;
`endif

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            on_q   <= '0;
            hit_q  <= '0;
            disp_q <= 1'b0;
            for (int i = 0; i < NBATS; i++) begin
                seg_q[i] <= 3'd0;
            end
        end else begin
            on_q   <= on_d;
            hit_q  <= hit_d;
            disp_q <= disp_d;
            for (int i = 0; i < NBATS; i++) begin
                seg_q[i] <= seg_d[i];
            end
        end
    end

    assign left_on    = on_q[0];
    assign right_on   = on_q[1];
    assign display_on = disp_q;
    assign left_seg   = seg_q[0];
    assign right_seg  = seg_q[1];
    assign left_hit   = hit_q[0];
    assign right_hit  = hit_q[1];

endmodule

// File: tb/tb_bats_renderer.sv
// Directed bench for bats_renderer: default instance plus a small-bat
// instance (HBITS=3, BAT_WIDTH=1, RIGHT_HPOS=511) sharing the same stimulus.
module tb_bats_renderer;

    logic       clk;
    logic       reset;
    logic [8:0] hpos;
    logic       hsync, vsync;
    logic       left_start, right_start;
    logic       ball_gfx;

    logic       left_on, right_on, display_on, left_hit, right_hit;
    logic [2:0] left_seg, right_seg;
    logic       left_on2, right_on2, display_on2, left_hit2, right_hit2;
    logic [2:0] left_seg2, right_seg2;

    int n_tests = 0;
    int n_fail  = 0;

    bats_renderer u_dut (
        .clk(clk), .reset(reset), .hpos(hpos), .hsync(hsync), .vsync(vsync),
        .left_start(left_start), .right_start(right_start), .ball_gfx(ball_gfx),
        .left_on(left_on), .right_on(right_on), .display_on(display_on),
        .left_seg(left_seg), .right_seg(right_seg),
        .left_hit(left_hit), .right_hit(right_hit)
    );

    bats_renderer #(.HBITS(3), .BAT_WIDTH(1), .RIGHT_HPOS(9'd511)) u_dut2 (
        .clk(clk), .reset(reset), .hpos(hpos), .hsync(hsync), .vsync(vsync),
        .left_start(left_start), .right_start(right_start), .ball_gfx(ball_gfx),
        .left_on(left_on2), .right_on(right_on2), .display_on(display_on2),
        .left_seg(left_seg2), .right_seg(right_seg2),
        .left_hit(left_hit2), .right_hit(right_hit2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_start(input logic l, input logic r);
        left_start  = l;
        right_start = r;
        tick();
        left_start  = 1'b0;
        right_start = 1'b0;
    endtask

    // One hsync high cycle then one low cycle; outputs afterwards show the new state.
    task automatic line_edge();
        hsync = 1'b1;
        tick();
        hsync = 1'b0;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".on"},  {29'd0, left_on, right_on, display_on}, 32'd0);
        check({tag, ".seg"}, {26'd0, left_seg, right_seg}, 32'd0);
        check({tag, ".hit"}, {30'd0, left_hit, right_hit}, 32'd0);
    endtask

    logic exp_hit;

    initial begin
        reset = 1'b1; hpos = 9'd16; hsync = 1'b0; vsync = 1'b0;
        left_start = 1'b0; right_start = 1'b0; ball_gfx = 1'b0;
`ifdef BATS_COLLISION_EN
        exp_hit = 1'b1;
`else
        exp_hit = 1'b0;
`endif
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;

        // Full 16-line sequence on the left bat.
        pulse_start(1'b1, 1'b0);
        check("armed.left_on", 32'(left_on), 32'd0);
        for (int k = 1; k <= 17; k++) begin
            line_edge();
            check($sformatf("seq.left_on.%0d", k), 32'(left_on), (k <= 16) ? 32'd1 : 32'd0);
            check($sformatf("seq.left_seg.%0d", k), 32'(left_seg), (k <= 16) ? 32'((k - 1) / 2) : 32'd0);
        end
        check("seq.right_on", 32'(right_on), 32'd0);

        // Restart mid-sequence at counter 9.
        do_reset();
        pulse_start(1'b1, 1'b0);
        for (int k = 1; k <= 10; k++) line_edge();
        check("restart.seg_before", 32'(left_seg), 32'd4);
        pulse_start(1'b1, 1'b0);
        tick();
        check("restart.armed_off", 32'(left_on), 32'd0);
        line_edge();
        check("restart.on", 32'(left_on), 32'd1);
        check("restart.seg0", 32'(left_seg), 32'd0);
        line_edge();
        line_edge();
        check("restart.seg_after2", 32'(left_seg), 32'd1);

        // Start coincident with line edge while ACTIVE: restart wins.
        hsync = 1'b1; left_start = 1'b1;
        tick();
        hsync = 1'b0; left_start = 1'b0;
        tick();
        check("coinc_active.off", 32'(left_on), 32'd0);
        line_edge();
        check("coinc_active.on", 32'(left_on), 32'd1);
        check("coinc_active.seg", 32'(left_seg), 32'd0);

        // Start coincident with line edge while IDLE: only ARMED.
        do_reset();
        hsync = 1'b1; left_start = 1'b1;
        tick();
        hsync = 1'b0; left_start = 1'b0;
        tick();
        check("coinc_idle.off", 32'(left_on), 32'd0);
        line_edge();
        check("coinc_idle.on", 32'(left_on), 32'd1);

        // Horizontal sweep with both bats active; hpos moves before sampling.
        do_reset();
        pulse_start(1'b1, 1'b1);
        line_edge();
        for (int h = 0; h < 512; h++) begin
            logic el, er;
            el = (h >= 16) && (h <= 19);
            er = (h >= 236) && (h <= 239);
            hpos = 9'(h);
            tick();
            hpos = 9'(h + 7);
            #1;
            check($sformatf("sweep.left.%0d", h), 32'(left_on), 32'(el));
            check($sformatf("sweep.right.%0d", h), 32'(right_on), 32'(er));
            check($sformatf("sweep.disp.%0d", h), 32'(display_on), 32'(el | er));
        end
        hpos = 9'd16;

        // Reset during ACTIVE at counter 5.
        do_reset();
        pulse_start(1'b1, 1'b0);
        for (int k = 1; k <= 6; k++) line_edge();
        check("abort.pre_seg", 32'(left_seg), 32'd2);
        do_reset();
        check_all_zero("abort");
        line_edge();
        line_edge();
        check("abort.no_vbat", 32'(left_on), 32'd0);
        pulse_start(1'b1, 1'b0);
        line_edge();
        check("abort.fresh_on", 32'(left_on), 32'd1);
        check("abort.fresh_seg", 32'(left_seg), 32'd0);

        // Collision flag: set, hold, clear on vsync rise.
        check("hit.pre", 32'(left_hit), 32'd0);
        ball_gfx = 1'b1;
        tick();
        ball_gfx = 1'b0;
        check("hit.set", 32'(left_hit), 32'(exp_hit));
        tick();
        tick();
        check("hit.hold", 32'(left_hit), 32'(exp_hit));
        check("hit.right", 32'(right_hit), 32'd0);
        vsync = 1'b1;
        tick();
        check("hit.clear", 32'(left_hit), 32'd0);
        tick();
        vsync = 1'b0;
        tick();
        check("hit.stay_clear", 32'(left_hit), 32'd0);

        // Small bat: 8 lines, segment steps every line.
        do_reset();
        pulse_start(1'b1, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            line_edge();
            check($sformatf("small.on.%0d", k), 32'(left_on2), (k <= 8) ? 32'd1 : 32'd0);
            check($sformatf("small.seg.%0d", k), 32'(left_seg2), (k <= 8) ? 32'(k - 1) : 32'd0);
        end

        // Small bat at the right edge: only hpos 511, no wrap.
        do_reset();
        pulse_start(1'b1, 1'b1);
        line_edge();
        for (int h = 0; h < 512; h++) begin
            hpos = 9'(h);
            tick();
            hpos = 9'(h + 3);
            #1;
            check($sformatf("small.right.%0d", h), 32'(right_on2), (h == 511) ? 32'd1 : 32'd0);
            check($sformatf("small.left.%0d", h), 32'(left_on2), (h == 16) ? 32'd1 : 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bats_renderer.md
BATS_RENDERER -- requirements
Module: bats_renderer

Interface
REQ-001 Parameter HBITS, default 4, meaning bat height is 2^HBITS scanlines; legal range 3..7.
REQ-002 Parameter BAT_WIDTH, default 4, meaning bat width in pixels; legal range 1..15.
REQ-003 Parameter LEFT_HPOS, default 9'd16, meaning first pixel column of the left bat.
REQ-004 Parameter RIGHT_HPOS, default 9'd236, meaning first pixel column of the right bat.
REQ-005 Port clk, input, 1 bit: pixel clock, the only clock.
REQ-006 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port hpos, input, 9 bits: current pixel column.
REQ-008 Port hsync, input, 1 bit: horizontal sync, active high.
REQ-009 Port vsync, input, 1 bit: vertical sync, active high.
REQ-010 Ports left_start and right_start, input, 1 bit each: one-cycle pulse that arms the vertical bat sequence.
REQ-011 Port ball_gfx, input, 1 bit: ball pixel is lit.
REQ-012 Ports left_on and right_on, output, 1 bit each: the bat pixel is lit.
REQ-013 Port display_on, output, 1 bit: left_on OR right_on.
REQ-014 Ports left_seg and right_seg, output, 3 bits each: bat segment index (0 = top, 7 = bottom).
REQ-015 Ports left_hit and right_hit, output, 1 bit each: sticky ball/bat collision flags.

Function
REQ-016 hsync and vsync rising edges are detected against a one-cycle registered copy of each signal; "line edge" means a cycle in which hsync is 1 and the registered copy is 0.
REQ-017 Each bat has a 3-state FSM (IDLE, ARMED, ACTIVE) and an HBITS-bit line counter.
REQ-018 IDLE goes to ARMED on a start pulse.
REQ-019 ARMED goes to ACTIVE on the next line edge, with the line counter set to 0.
REQ-020 In ACTIVE, each line edge increments the line counter.
REQ-021 In ACTIVE, a line edge with the line counter at 2^HBITS-1 returns the FSM to IDLE; no ACTIVE line is skipped or repeated.
REQ-022 A start pulse in ARMED or ACTIVE forces ARMED; this restart has priority over a coincident line edge.
REQ-023 A start pulse coincident with a line edge while IDLE gives ARMED; ACTIVE begins at the following line edge.
REQ-024 The vertical window vbat is 1 exactly while the FSM is ACTIVE.
REQ-025 The segment index is the top 3 bits of the line counter; it is 0 while the FSM is not ACTIVE.
REQ-026 The horizontal window is true when hpos >= XPOS and hpos <= XPOS+BAT_WIDTH-1, computed at 10 bits with no wrap; XPOS is the bat's HPOS parameter.
REQ-027 left_on, right_on, left_seg and right_seg are registered: the value for the hpos and state sampled in cycle N appears in cycle N+1.
REQ-028 display_on is registered together with left_on and right_on, with the same 1-cycle latency.

Reset
REQ-029 On reset high at a clk edge, both FSMs go to IDLE and both line counters go to 0.
REQ-030 On reset, the edge-detect registers go to 0 and all outputs go to 0, including the hit flags.
REQ-031 Reset takes priority over start pulses and over line edges.
REQ-032 Reset during ACTIVE aborts the bat; the next start pulse begins a fresh sequence.

Configuration
REQ-033 Macro BATS_COLLISION_EN compiles collision detection in or out.
REQ-034 With BATS_COLLISION_EN defined: a hit flag sets when, in the same cycle, ball_gfx=1 and the registered bat-lit output is 1.
REQ-035 With BATS_COLLISION_EN defined: a hit flag holds until a vsync rising edge clears it; a set and a clear in the same cycle resolve to set.
REQ-036 Without BATS_COLLISION_EN: all ports remain present, left_hit and right_hit are constant 0, and ball_gfx is ignored.

Verification
REQ-037 Defaults; left_start pulse, then line edges 1..17 -> vbat ACTIVE for exactly lines 1..16; left_seg 0,0,1,1,...,7,7; IDLE after the 17th edge.
REQ-038 ACTIVE at line counter 9, left_start pulse -> ARMED; the next line edge restarts with the counter at 0 and left_seg=0.
REQ-039 ACTIVE; sweep hpos 0..511 -> left_on=1 exactly for hpos 16..19 and right_on=1 exactly for hpos 236..239, each delayed 1 cycle; display_on equals their OR.
REQ-040 ACTIVE at counter 5, reset for one cycle -> next cycle all outputs 0, FSM IDLE, no vbat until a new start pulse.
REQ-041 BATS_COLLISION_EN defined; ball_gfx=1 while left_on=1 -> left_hit=1 the next cycle, held; vsync rising -> left_hit=0. Without the macro, the same stimulus -> left_hit stays 0.
REQ-042 HBITS=3, BAT_WIDTH=1, RIGHT_HPOS=9'd511 -> 8-line bat, left_seg increments every line, right_on lit only at hpos 511, no wrap to hpos 0.
